// File: rtl/mc_issue_ctrl.sv
// mc_issue_ctrl: sequences the multi-cycle mul/div unit for the E stage, stalling and bubbling around it
module mc_issue_ctrl #(
  parameter int TIMEOUT = 64
) (
  input  logic        CLK,
  input  logic        ResetN,
  input  logic        MCReqE,
  input  logic [1:0]  MCOpE,
  input  logic        MCDone,
  input  logic        HoldM,
  output logic        MCStart,
  output logic [1:0]  MCOp,
  output logic        MCAbort,
  output logic        StallFDE,
  output logic        EN_EM,
  output logic        BubbleEM,
  output logic        ResultSelE,
  output logic        RegWrite2En,
  output logic        ErrSticky,
  output logic [15:0] StallCount
);
  localparam int CW = $clog2(TIMEOUT + 1);
  typedef enum logic [2:0] {IDLE, START, WAIT, DONE, ABORT} state_t;
  state_t state;
  logic [CW-1:0] wdog;
  logic [CW-1:0] wdog_nxt;
  logic done_lat;
  logic ab_seen;
  assign wdog_nxt = wdog + CW'(1);
  // sequencing state, watchdog, done catch, sticky error and saturating stall counter
  always_ff @(posedge CLK) begin
    if (!ResetN) begin
      state      <= IDLE;
      MCOp       <= '0;
      ErrSticky  <= 1'b0;
      StallCount <= '0;
      wdog       <= '0;
      done_lat   <= 1'b0;
      ab_seen    <= 1'b0;
    end else begin
      ab_seen <= state == ABORT;
      if (StallFDE && StallCount != 16'hFFFF) StallCount <= StallCount + 16'd1;
      case (state)
        IDLE: if (MCReqE && !HoldM) begin
          state <= START;
          MCOp  <= MCOpE;
        end
        START: begin
          wdog     <= '0;
          done_lat <= 1'b0;
          state    <= WAIT;
        end
        WAIT: begin
          if (MCDone) done_lat <= 1'b1;
          if (MCDone || done_lat) state <= DONE;
          else begin
            wdog <= wdog_nxt;
            if (wdog_nxt == CW'(TIMEOUT - 1)) state <= ABORT;
          end
        end
        DONE: if (!HoldM) state <= IDLE;
        ABORT: begin
          ErrSticky <= 1'b1;
          if (!HoldM) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
  // pipeline control decoded from state; the abort pulse is limited to the first ABORT cycle
  always_comb begin
    MCStart     = state == START;
    MCAbort     = state == ABORT && !ab_seen;
    EN_EM       = !HoldM;
    ResultSelE  = state == DONE || state == ABORT;
    RegWrite2En = state == DONE && MCOp == 2'b01;
    StallFDE    = state == IDLE ? MCReqE : (state == DONE || state == ABORT) ? HoldM : 1'b1;
    BubbleEM    = state == IDLE ? MCReqE : state != DONE;
  end
endmodule

// File: tb/tb_mc_issue_ctrl.sv
// tb_mc_issue_ctrl: directed and random checks of mc_issue_ctrl against a cycle-phase reference model
module tb_mc_issue_ctrl;
  localparam int TO = 8;
  logic clk = 1'b0;
  logic rstn, req, done, hold;
  logic [1:0] op;
  logic mc_start, mc_abort, stall, en_em, bubble, rsel, rw2, err;
  logic [1:0] mc_op;
  logic [15:0] cnt;
  int total = 0;
  int bad = 0;
  int n_start, n_stall, n_abort;
  int m_pos = -1;
  int m_fin = 0;
  int m_fin_age = 0;
  bit m_caught = 0;
  int m_op = 0;
  bit m_err = 0;
  int m_cnt = 0;

  always #5 clk = ~clk;

  mc_issue_ctrl #(.TIMEOUT(TO)) dut (
    .CLK(clk), .ResetN(rstn), .MCReqE(req), .MCOpE(op), .MCDone(done), .HoldM(hold),
    .MCStart(mc_start), .MCOp(mc_op), .MCAbort(mc_abort), .StallFDE(stall), .EN_EM(en_em),
    .BubbleEM(bubble), .ResultSelE(rsel), .RegWrite2En(rw2), .ErrSticky(err), .StallCount(cnt)
  );

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step(input bit r, input bit [1:0] o, input bit d, input bit h, input bit rn, input bit ck);
    bit idle, e_stall;
    @(negedge clk);
    req = r; op = o; done = d; hold = h; rstn = rn;
    #2;
    idle = m_fin == 0 && m_pos < 0;
    e_stall = idle ? r : (m_fin != 0 ? h : 1'b1);
    n_start += int'(mc_start === 1'b1);
    n_stall += int'(stall === 1'b1);
    n_abort += int'(mc_abort === 1'b1);
    if (ck) begin
      chk("stall", 16'(stall), 16'(e_stall));
      chk("bubble", 16'(bubble), 16'(idle ? r : m_fin != 1));
      chk("en_em", 16'(en_em), 16'(!h));
      chk("start", 16'(mc_start), 16'(m_fin == 0 && m_pos == 0));
      chk("abort", 16'(mc_abort), 16'(m_fin == 2 && m_fin_age == 0));
      chk("rsel", 16'(rsel), 16'(m_fin != 0));
      chk("rw2", 16'(rw2), 16'(m_fin == 1 && m_op == 1));
      chk("mcop", 16'(mc_op), 16'(m_op));
      chk("err", 16'(err), 16'(m_err));
      chk("count", cnt, 16'(m_cnt));
    end
    if (!rn) begin
      m_pos = -1; m_fin = 0; m_op = 0; m_err = 0; m_cnt = 0; m_caught = 0;
    end else begin
      m_cnt = (m_cnt + int'(e_stall) > 65535) ? 65535 : m_cnt + int'(e_stall);
      if (m_fin != 0) begin
        if (m_fin == 2) m_err = 1;
        m_fin_age++;
        if (!h) begin m_fin = 0; m_pos = -1; end
      end else if (m_pos < 0) begin
        if (r && !h) begin m_pos = 0; m_op = o; end
      end else if (m_pos == 0) begin
        m_pos = 1; m_caught = 0;
      end else begin
        m_caught |= d;
        if (m_caught) begin m_fin = 1; m_fin_age = 0; end
        else if (m_pos == TO - 1) begin m_fin = 2; m_fin_age = 0; end
        else m_pos++;
      end
    end
  endtask

  task automatic clr();
    n_start = 0; n_stall = 0; n_abort = 0;
  endtask

  initial begin
    clr();
    step(0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 1, 1);
    chk("reset_count", cnt, 16'h0000);
    chk("reset_err", 16'(err), 16'h0000);
    // T1 plain MUL, done three cycles after start
    clr();
    step(1, 0, 0, 0, 1, 1);
    step(0, 0, 0, 0, 1, 1);
    step(0, 0, 0, 0, 1, 1);
    step(0, 0, 0, 0, 1, 1);
    step(0, 0, 1, 0, 1, 1);
    chk("t1_done_rsel", 16'(rsel), 16'h0000);
    step(0, 0, 0, 0, 1, 1);
    chk("t1_rsel", 16'(rsel), 16'h0001);
    chk("t1_bubble", 16'(bubble), 16'h0000);
    step(0, 0, 0, 0, 1, 1);
    chk("t1_starts", 16'(n_start), 16'd1);
    chk("t1_stalls", 16'(n_stall), 16'd5);
    // T2 long MUL
    step(1, 1, 0, 0, 1, 1);
    step(0, 0, 0, 0, 1, 1);
    step(0, 0, 1, 0, 1, 1);
    step(0, 0, 0, 0, 1, 1);
    chk("t2_rw2", 16'(rw2), 16'h0001);
    chk("t2_op", 16'(mc_op), 16'h0001);
    step(0, 0, 0, 0, 1, 1);
    // T3 hold across done pulse and two DONE cycles
    step(1, 2, 0, 0, 1, 1);
    step(0, 0, 0, 0, 1, 1);
    step(0, 0, 0, 1, 1, 1);
    step(0, 0, 1, 1, 1, 1);
    step(0, 0, 0, 1, 1, 1);
    chk("t3_hold_stall", 16'(stall), 16'h0001);
    step(0, 0, 0, 1, 1, 1);
    step(0, 0, 0, 0, 1, 1);
    step(0, 0, 0, 0, 1, 1);
    // T4 timeout, then a normal op
    clr();
    step(1, 3, 0, 0, 1, 1);
    for (int i = 0; i < 12; i++) step(0, 0, 0, 0, 1, 1);
    chk("t4_err", 16'(err), 16'h0001);
    chk("t4_aborts", 16'(n_abort), 16'd1);
    step(1, 0, 0, 0, 1, 1);
    step(0, 0, 0, 0, 1, 1);
    step(0, 0, 1, 0, 1, 1);
    step(0, 0, 0, 0, 1, 1);
    step(0, 0, 0, 0, 1, 1);
    // T5 reset while waiting
    clr();
    step(1, 2, 0, 0, 1, 1);
    step(0, 0, 0, 0, 1, 1);
    step(0, 0, 0, 0, 1, 1);
    step(0, 0, 0, 0, 0, 1);
    step(1, 0, 0, 0, 1, 1);
    chk("t5_aborts", 16'(n_abort), 16'd0);
    step(0, 0, 0, 0, 1, 1);
    // T6 back-to-back DIV then MUL
    step(1, 2, 0, 0, 1, 1);
    step(1, 2, 0, 0, 1, 1);
    step(1, 2, 1, 0, 1, 1);
    step(1, 0, 0, 0, 1, 1);
    step(1, 0, 0, 0, 1, 1);
    step(0, 0, 0, 0, 1, 1);
    chk("t6_second_start", 16'(mc_start), 16'h0001);
    step(0, 0, 1, 0, 1, 1);
    step(0, 0, 0, 0, 1, 1);
    step(0, 0, 0, 0, 1, 1);
    // random traffic
    for (int i = 0; i < 1500; i++)
      step($urandom_range(1, 0) == 1, 2'($urandom_range(3, 0)), $urandom_range(5, 0) == 0,
           $urandom_range(4, 0) == 0, $urandom_range(199, 0) != 0, 1);
    // saturation under a long held request
    step(0, 0, 0, 0, 0, 1);
    for (int i = 0; i < 65540; i++) step(1, 0, 0, 1, 1, 1);
    chk("sat_count", cnt, 16'hFFFF);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
